// File: rtl/aes_iterative_core.sv
// aes_iterative_core: handshaked AES-128/192/256 core, one round per clock,
// encrypt or decrypt selected per block. Single block in flight.
// Optional abort input enabled by defining AES_ABORT_EN.
// Note: the initial AddRoundKey is folded into the first ROUND edge because
// the key register (and so the key schedule) only holds the new key after
// the accept edge. Result and latency are unchanged.
module aes_iterative_core #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  input  logic [N-1:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NR = (N == 128) ? 10 : (N == 192) ? 12 : 14;
  localparam int NK = N / 32;
  localparam int NW = 4 * (NR + 1);
  localparam logic [3:0] NR4 = 4'(NR);

  if (!(N == 128 || N == 192 || N == 256)) begin : g_bad_n
    $error("aes_iterative_core: N must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic         mode_q, mode_d;
  logic [N-1:0] key_q, key_d;
  logic [127:0] data_q, data_d, out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] rk [0:15];
  logic [127:0] round_out;
  logic         accept, abort_hit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction

  // byte r+4c sits at s[127-8*(r+4c) -: 8]; row r rotates left by r (right when inverse)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*(inv ? (c+4-r)%4 : (c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   x [4];
    logic [7:0]   c0, c1, c2, c3;
    {c0, c1, c2, c3} = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) x[i] = s[127-8*(i+4*c) -: 8];
      for (int i = 0; i < 4; i++)
        o[127-8*(i+4*c) -: 8] = gmul(c0, x[i]) ^ gmul(c1, x[(i+1)%4]) ^
                                gmul(c2, x[(i+2)%4]) ^ gmul(c3, x[(i+3)%4]);
    end
    return o;
  endfunction

  // key schedule: all round keys from the registered key; unused slots are zero
  always_comb begin : key_expand
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 64; i++) w[i] = '0;
    rcon = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = key_q[N-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  end

  // one cipher round (full or last) on the state register
  always_comb begin : round_path
    logic [127:0] s, v;
    logic [3:0]   idx;
    logic         last;
    last = (state_q == FINAL);
    if (mode_q) idx = last ? 4'd0 : NR4 - rc_q;
    else        idx = last ? NR4 : rc_q;
    s = (state_q == ROUND && rc_q == 4'd1) ? data_q ^ rk[mode_q ? NR4 : 4'd0] : data_q;
    if (mode_q) begin
      v = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[idx];
      round_out = last ? v : mix_columns(v, 1'b1);
    end else begin
      v = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      round_out = (last ? v : mix_columns(v, 1'b0)) ^ rk[idx];
    end
  end

  assign in_ready  = (state_q == IDLE) && !out_valid_q;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef AES_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  // next-state: accept, round sequencing, output handshake, abort
  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    mode_d      = mode_q;
    key_d       = key_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (abort_hit) begin
      state_d = IDLE;
      rc_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          key_d   = in_key;
          mode_d  = in_mode;
          data_d  = in_data;
          rc_d    = 4'd1;
          state_d = ROUND;
        end
        ROUND: begin
          data_d = round_out;
          rc_d   = rc_q + 4'd1;
          if (rc_q == NR4 - 4'd1) state_d = FINAL;
        end
        FINAL: begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          rc_d        = '0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rc_q        <= '0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_aes_iterative_core.sv
// Scoreboard bench for aes_iterative_core: three instances (N=128/192/256),
// directed FIPS-197 vectors, backpressure, mid-block reset, and abort when
// AES_ABORT_EN is defined.
module tb_aes_iterative_core;
  logic         clk, rst_n;
  logic         in_valid [3];
  logic         in_ready [3];
  logic         in_mode  [3];
  logic [127:0] in_data  [3];
  logic [255:0] in_key   [3];
  logic         out_valid[3];
  logic         out_ready[3];
  logic [127:0] out_data [3];
  logic         busy     [3];
`ifdef AES_ABORT_EN
  logic         abort_s  [3];
`endif

  typedef struct {
    int           id;
    logic [127:0] data;
    int           acc;
    int           nr;
  } exp_t;
  exp_t q[$];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_ov [3];

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_iterative_core #(.N(128)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mode(in_mode[0]), .in_data(in_data[0]), .in_key(in_key[0][127:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
`ifdef AES_ABORT_EN
    .abort(abort_s[0]),
`endif
    .out_data(out_data[0]), .busy(busy[0]));

  aes_iterative_core #(.N(192)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mode(in_mode[1]), .in_data(in_data[1]), .in_key(in_key[1][191:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
`ifdef AES_ABORT_EN
    .abort(abort_s[1]),
`endif
    .out_data(out_data[1]), .busy(busy[1]));

  aes_iterative_core #(.N(256)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_mode(in_mode[2]), .in_data(in_data[2]), .in_key(in_key[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
`ifdef AES_ABORT_EN
    .abort(abort_s[2]),
`endif
    .out_data(out_data[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input int k, input logic mode, input logic [127:0] data,
                      input logic [255:0] key, input logic [127:0] exp);
    int t = 0;
    exp_t e;
    while (!in_ready[k] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[k]) begin
      chk("in_ready_timeout", 128'(in_ready[k]), 128'd1);
    end else begin
      in_valid[k] = 1'b1;
      in_mode[k]  = mode;
      in_data[k]  = data;
      in_key[k]   = key;
      @(posedge clk); #1;
      e.id = k; e.data = exp; e.acc = cyc; e.nr = 10 + 2 * k;
      q.push_back(e);
      in_valid[k] = 1'b0;
      in_mode[k]  = ~mode;
      in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
      in_key[k]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic wait_out(input int k);
    int t = 0;
    while (!out_valid[k] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid[k]) chk("out_valid_timeout", 128'(out_valid[k]), 128'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("scoreboard_drain", 128'(q.size()), 128'd0);
  endtask

  // monitor: latency on rising out_valid, data on each handshake
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k] && !prev_ov[k]) begin
        if (q.size() == 0 || q[0].id != k) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output inst %0d: got %h, expected no output", k, out_data[k]);
        end else begin
          chk($sformatf("latency_inst%0d", k), 128'(cyc - q[0].acc), 128'(q[0].nr));
        end
      end
      if (out_valid[k] && out_ready[k] && q.size() != 0 && q[0].id == k) begin
        chk($sformatf("data_inst%0d", k), out_data[k], q[0].data);
        q.delete(0);
      end
      prev_ov[k] = out_valid[k];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_mode[k] = 1'b0; in_data[k] = '0; in_key[k] = '0;
      out_ready[k] = 1'b1; prev_ov[k] = 1'b0;
`ifdef AES_ABORT_EN
      abort_s[k] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_busy", 128'(busy[0]), 128'd0);
    chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("rst_out_data", out_data[0], 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // encrypt and decrypt round trips for each key size
    send(0, 1'b0, PT, K128, CT0);  drain();
    send(0, 1'b1, CT0, K128, PT);  drain();
    send(1, 1'b0, PT, K192, CT1);  drain();
    send(1, 1'b1, CT1, K192, PT);  drain();
    send(2, 1'b0, PT, K256, CT2);  drain();
    send(2, 1'b1, CT2, K256, PT);  drain();

    // back-to-back with out_ready held high
    send(0, 1'b0, PT, K128, CT0);
    send(0, 1'b1, CT0, K128, PT);
    send(0, 1'b0, PT, K128, CT0);
    drain();

    // backpressure: result held, second request ignored
    out_ready[0] = 1'b0;
    send(0, 1'b0, PT, K128, CT0);
    wait_out(0);
    in_valid[0] = 1'b1; in_mode[0] = 1'b1; in_data[0] = CT0; in_key[0] = K128;
    for (int i = 0; i < 20; i++) begin
      chk("hold_out_data", out_data[0], CT0);
      chk("hold_out_valid", 128'(out_valid[0]), 128'd1);
      chk("hold_in_ready", 128'(in_ready[0]), 128'd0);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    chk("hold_not_accepted", 128'(busy[0]), 128'd0);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 128'(out_valid[0]), 128'd0);
    chk("release_in_ready", 128'(in_ready[0]), 128'd1);
    drain();

    // reset in the middle of a block
    send(0, 1'b0, PT, K128, CT0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst_busy", 128'(busy[0]), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_output", 128'(out_valid[0]), 128'd0);
    send(0, 1'b0, PT, K128, CT0);
    drain();

`ifdef AES_ABORT_EN
    // abort at round 3 with key changed mid-block, then a fresh block
    send(0, 1'b0, PT, {128'h0, {4{32'hffffffff}}}, '0);
    in_key[0] = K128;
    repeat (2) @(posedge clk);
    #1;
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    void'(q.pop_back());
    chk("abort_busy", 128'(busy[0]), 128'd0);
    chk("abort_in_ready", 128'(in_ready[0]), 128'd1);
    chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_output", 128'(out_valid[0]), 128'd0);
    send(0, 1'b1, CT0, K128, PT);
    drain();

    // abort while idle does not clear a pending result
    out_ready[0] = 1'b0;
    send(0, 1'b0, PT, K128, CT0);
    wait_out(0);
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    chk("idle_abort_out_valid", 128'(out_valid[0]), 128'd1);
    out_ready[0] = 1'b1;
    drain();
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
